// File: rtl/run_detect_pkg.sv
// Shared types and defaults for the run-detect scheduler: FSM state encoding,
// default geometry and the requester-id width helper.
package run_detect_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} rds_state_t;

   localparam int RDS_NREQ    = 4;
   localparam int RDS_NBITS   = 8;
   localparam int RDS_RUN_LEN = 2;

   function automatic int id_w(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_detect_scheduler_detector.sv
// Serial run detector: tracks the current run of equal bits and captures hit,
// first completion index and completion count. Outputs already include the bit on bit_in when en=1.
module run_detector
   import run_detect_pkg::*;
#(
   parameter  int NBITS   = RDS_NBITS,
   parameter  int RUN_LEN = RDS_RUN_LEN,
   localparam int POS_W   = $clog2(NBITS),
   localparam int CNT_W   = $clog2(NBITS + 1),
   localparam int LEN_W   = $clog2(RUN_LEN + 1)
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [LEN_W-1:0] run_len,
   output logic             hit,
   output logic [POS_W-1:0] first_pos,
   output logic [CNT_W-1:0] hit_count
);

   logic [LEN_W-1:0] r_len;
   logic             r_prev;
   logic             r_started;
   logic [POS_W-1:0] r_idx;
   logic             r_hit;
   logic [POS_W-1:0] r_pos;
   logic [CNT_W-1:0] r_cnt;

   logic [LEN_W-1:0] w_len;
   logic             w_match;
   logic             w_hit;
   logic [POS_W-1:0] w_pos;
   logic [CNT_W-1:0] w_cnt;

   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] len);
      return (len >= LEN_W'(RUN_LEN)) ? LEN_W'(RUN_LEN) : len + 1'b1;
   endfunction

   always_comb begin
      w_len   = r_len;
      w_match = 1'b0;
      w_hit   = r_hit;
      w_pos   = r_pos;
      w_cnt   = r_cnt;
      if (en) begin
         if (r_started && (bit_in == r_prev)) w_len = sat_inc(r_len);
         else                                 w_len = LEN_W'(1);
         w_match = (w_len == LEN_W'(RUN_LEN));
         if (w_match) begin
            w_cnt = r_cnt + 1'b1;
            if (!r_hit) w_pos = r_idx;
            w_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_2) begin
      if (!reset || clr) begin
         r_len     <= '0;
         r_prev    <= 1'b0;
         r_started <= 1'b0;
         r_idx     <= '0;
         r_hit     <= 1'b0;
         r_pos     <= '0;
         r_cnt     <= '0;
      end else if (en) begin
         r_len     <= w_len;
         r_prev    <= bit_in;
         r_started <= 1'b1;
         r_idx     <= r_idx + 1'b1;
         r_hit     <= w_hit;
         r_pos     <= w_pos;
         r_cnt     <= w_cnt;
      end
   end

   assign run_len   = w_len;
   assign hit       = w_hit;
   assign first_pos = w_pos;
   assign hit_count = w_cnt;

endmodule

// File: rtl/run_detect_scheduler.sv
// Arbitrates NREQ requesters onto one serial run detector and reports per-job results.
// Define RDS_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module run_detect_scheduler
   import run_detect_pkg::*;
#(
   parameter  int NREQ    = RDS_NREQ,
   parameter  int NBITS   = RDS_NBITS,
   parameter  int RUN_LEN = RDS_RUN_LEN,
   localparam int ID_W    = id_w(NREQ),
   localparam int POS_W   = $clog2(NBITS),
   localparam int CNT_W   = $clog2(NBITS + 1),
   localparam int LEN_W   = $clog2(RUN_LEN + 1)
) (
   input  logic                        clk_2,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ-1:0][NBITS-1:0]  data,
   output logic [NREQ-1:0]             grant,
   output logic                        busy,
   output logic                        done,
   output logic [ID_W-1:0]             done_id,
   output logic                        hit,
   output logic [POS_W-1:0]            first_pos,
   output logic [CNT_W-1:0]            hit_count
);

   rds_state_t       r_state;
   logic [ID_W-1:0]  r_win;
   logic [POS_W-1:0] r_bit_idx;
   logic [NBITS-1:0] r_word;
   logic [NREQ-1:0]  r_grant;
   logic             r_busy;
   logic             r_done;
   logic [ID_W-1:0]  r_done_id;
   logic             r_hit;
   logic [POS_W-1:0] r_first_pos;
   logic [CNT_W-1:0] r_hit_count;

   logic [ID_W-1:0]  w_win;
   logic             w_any;
   logic             w_det_clr;
   logic             w_det_en;
   logic [LEN_W-1:0] w_run_len_unused;
   logic             w_det_hit;
   logic [POS_W-1:0] w_det_pos;
   logic [CNT_W-1:0] w_det_cnt;

`ifdef RDS_FIXED_PRIO_EN
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_any && req[k]) begin
            w_win = ID_W'(k);
            w_any = 1'b1;
         end
      end
   end
`else
   logic [ID_W-1:0] r_rr;

   function automatic logic [ID_W-1:0] rr_wrap(input logic [ID_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return ID_W'(s);
   endfunction

   // Scan starts at the pointer so the last winner is considered last.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_any && req[rr_wrap(r_rr, k)]) begin
            w_win = rr_wrap(r_rr, k);
            w_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_2) begin
      if (!reset)
         r_rr <= '0;
      else if (r_state == REPORT)
         r_rr <= (r_win == ID_W'(NREQ - 1)) ? '0 : r_win + 1'b1;
   end
`endif

   always_ff @(posedge clk_2) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_win       <= '0;
         r_bit_idx   <= '0;
         r_grant     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_done_id   <= '0;
         r_hit       <= 1'b0;
         r_first_pos <= '0;
         r_hit_count <= '0;
      end else begin
         r_grant <= '0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= LOAD;
                  r_win   <= w_win;
                  r_grant <= NREQ'(1) << w_win;
                  r_busy  <= 1'b1;
               end
            end
            LOAD: begin
               r_bit_idx <= '0;
               r_state   <= SHIFT;
            end
            SHIFT: begin
               r_bit_idx <= r_bit_idx + 1'b1;
               if (r_bit_idx == POS_W'(NBITS - 1)) begin
                  r_state     <= REPORT;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_done_id   <= r_win;
                  r_hit       <= w_det_hit;
                  r_first_pos <= w_det_pos;
                  r_hit_count <= w_det_cnt;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Word register: loaded in LOAD, shifted MSB-first in SHIFT.
   always_ff @(posedge clk_2) begin
      if (r_state == LOAD)
         r_word <= data[r_win];
      else if (r_state == SHIFT)
         r_word <= {r_word[NBITS-2:0], 1'b0};
   end

   assign w_det_clr = (r_state == LOAD);
   assign w_det_en  = (r_state == SHIFT);

   run_detector #(
      .NBITS   (NBITS),
      .RUN_LEN (RUN_LEN)
   ) u_det (
      .clk_2     (clk_2),
      .reset     (reset),
      .clr       (w_det_clr),
      .en        (w_det_en),
      .bit_in    (r_word[NBITS-1]),
      .run_len   (w_run_len_unused),
      .hit       (w_det_hit),
      .first_pos (w_det_pos),
      .hit_count (w_det_cnt)
   );

   assign grant     = r_grant;
   assign busy      = r_busy;
   assign done      = r_done;
   assign done_id   = r_done_id;
   assign hit       = r_hit;
   assign first_pos = r_first_pos;
   assign hit_count = r_hit_count;

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Scoreboard bench for run_detect_scheduler (NREQ=4, NBITS=8, RUN_LEN=2).
module tb_run_detect_scheduler;

   localparam int NREQ    = 4;
   localparam int NBITS   = 8;
   localparam int RUN_LEN = 2;
   localparam int ID_W    = 2;
   localparam int POS_W   = 3;
   localparam int CNT_W   = 4;

   logic                       clk_2 = 1'b0;
   logic                       reset = 1'b0;
   logic [NREQ-1:0]            req   = '0;
   logic [NREQ-1:0][NBITS-1:0] data  = '0;
   logic [NREQ-1:0]            grant;
   logic                       busy;
   logic                       done;
   logic [ID_W-1:0]            done_id;
   logic                       hit;
   logic [POS_W-1:0]           first_pos;
   logic [CNT_W-1:0]           hit_count;

   typedef struct {
      int id;
      bit hit;
      int pos;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_rr    = 0;

   always #5 clk_2 = ~clk_2;

   run_detect_scheduler #(.NREQ(NREQ), .NBITS(NBITS), .RUN_LEN(RUN_LEN)) dut (
      .clk_2     (clk_2),
      .reset     (reset),
      .req       (req),
      .data      (data),
      .grant     (grant),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .hit       (hit),
      .first_pos (first_pos),
      .hit_count (hit_count)
   );

   function automatic exp_t mk(input int id, input bit h, input int p, input int c);
      exp_t e;
      e.id = id; e.hit = h; e.pos = p; e.cnt = c;
      return e;
   endfunction

   function automatic exp_t model(input int id, input logic [NBITS-1:0] w);
      exp_t e;
      int   len;
      e = mk(id, 1'b0, 0, 0);
      len = 0;
      for (int i = 0; i < NBITS; i++) begin
         if (i > 0 && w[NBITS-1-i] == w[NBITS-i]) len = (len < RUN_LEN) ? len + 1 : RUN_LEN;
         else len = 1;
         if (len == RUN_LEN) begin
            if (!e.hit) e.pos = i;
            e.hit = 1'b1;
            e.cnt++;
         end
      end
      return e;
   endfunction

   function automatic int pick(input logic [NREQ-1:0] m);
`ifdef RDS_FIXED_PRIO_EN
      for (int k = 0; k < NREQ; k++) if (m[k]) return k;
`else
      for (int k = 0; k < NREQ; k++) if (m[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
`endif
      return -1;
   endfunction

   always @(negedge clk_2) begin
      if (reset && done) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: got done_id=%0d, required no done", done_id);
         end else begin
            exp_t e;
            e = sb.pop_front();
            m_rr = (e.id + 1) % NREQ;
            n_tests++;
            if (done_id !== ID_W'(e.id)) begin
               n_fail++; $display("FAIL done_id: got %0d, required %0d", done_id, e.id);
            end
            n_tests++;
            if (hit !== e.hit) begin
               n_fail++; $display("FAIL hit (id %0d): got %b, required %b", e.id, hit, e.hit);
            end
            n_tests++;
            if (first_pos !== POS_W'(e.pos)) begin
               n_fail++; $display("FAIL first_pos (id %0d): got %0d, required %0d", e.id, first_pos, e.pos);
            end
            n_tests++;
            if (hit_count !== CNT_W'(e.cnt)) begin
               n_fail++; $display("FAIL hit_count (id %0d): got %0d, required %0d", e.id, hit_count, e.cnt);
            end
         end
      end
   end

   task automatic drive_req(input logic [NREQ-1:0] m, output logic [NREQ-1:0] g, output int cyc);
      req = m;
      g   = '0;
      cyc = 0;
      while (cyc < 30 && g == '0) begin
         @(negedge clk_2);
         cyc++;
         g = grant;
      end
      req = '0;
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while ((sb.size() != 0 || busy) && c < 40) begin
         @(negedge clk_2);
         c++;
      end
      n_tests++;
      if (sb.size() != 0 || busy) begin
         n_fail++;
         $display("FAIL %s_timeout: pending=%0d busy=%b, required 0/0", name, sb.size(), busy);
      end
      @(negedge clk_2);
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      req     = '1;
      data[0] = 8'hAA;
      repeat (2) @(negedge clk_2);
      n_tests++;
      if ({grant, busy, done, done_id, hit, first_pos, hit_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got grant=%b busy=%b done=%b id=%0d hit=%b pos=%0d cnt=%0d, required all 0",
                  grant, busy, done, done_id, hit, first_pos, hit_count);
      end
      reset = 1'b1;
      m_rr  = 0;
      sb.push_back(mk(0, 1'b0, 0, 0));
      @(negedge clk_2);
      n_tests++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL reset_first_grant: got %b, required 0001", grant);
      end
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_busy: got %b, required 1", busy);
      end
      req = '0;
      wait_idle("reset_job");
   endtask

   task automatic test_no_run();
      logic [NREQ-1:0] g;
      int              cyc;
      int              lat;
      data[0] = 8'hAA;
      sb.push_back(mk(0, 1'b0, 0, 0));
      drive_req(4'b0001, g, cyc);
      n_tests++;
      if (g !== 4'b0001 || cyc != 1) begin
         n_fail++; $display("FAIL grant_latency: got grant=%b after %0d, required 0001 after 1", g, cyc);
      end
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk_2);
         lat++;
      end
      n_tests++;
      if (lat != NBITS + 1) begin
         n_fail++; $display("FAIL done_latency: got %0d cycles after grant, required %0d", lat, NBITS + 1);
      end
      wait_idle("no_run");
   endtask

   task automatic test_mixed();
      logic [NREQ-1:0] g;
      int              cyc;
      data[1] = 8'b0011_0110;
      sb.push_back(mk(1, 1'b1, 1, 3));
      drive_req(4'b0010, g, cyc);
      n_tests++;
      if (g !== 4'b0010) begin
         n_fail++; $display("FAIL mixed_grant: got %b, required 0010", g);
      end
      wait_idle("mixed");
      data[3] = 8'hAA;
      sb.push_back(mk(3, 1'b0, 0, 0));
      drive_req(4'b1000, g, cyc);
      @(negedge clk_2);
      n_tests++;
      if (hit !== 1'b1 || hit_count !== 4'd3 || first_pos !== 3'd1) begin
         n_fail++;
         $display("FAIL result_hold: got hit=%b cnt=%0d pos=%0d, required 1/3/1", hit, hit_count, first_pos);
      end
      wait_idle("hold");
   endtask

   task automatic test_all_equal();
      logic [NREQ-1:0] g;
      int              cyc;
      data[2] = 8'hFF;
      sb.push_back(mk(2, 1'b1, 1, 7));
      drive_req(4'b0100, g, cyc);
      @(negedge clk_2);
      data[2] = 8'hAA;
      wait_idle("all_ones");
      data[2] = 8'h00;
      sb.push_back(mk(2, 1'b1, 1, 7));
      drive_req(4'b0100, g, cyc);
      n_tests++;
      if (g !== 4'b0100) begin
         n_fail++; $display("FAIL zeros_grant: got %b, required 0100", g);
      end
      wait_idle("all_zeros");
   endtask

   task automatic test_random();
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] m;
      logic [NREQ-1:0] eg;
      int              cyc;
      int              w;
      for (int k = 0; k < 6; k++) begin
         m       = NREQ'($urandom_range(1, 15));
         w       = pick(m);
         data[w] = NBITS'($urandom);
         sb.push_back(model(w, data[w]));
         eg      = '0;
         eg[w]   = 1'b1;
         drive_req(m, g, cyc);
         n_tests++;
         if (g !== eg) begin
            n_fail++; $display("FAIL random_grant[%0d] req=%b: got %b, required %b", k, m, g, eg);
         end
         wait_idle("random");
      end
   endtask

   task automatic test_back_to_back();
      int              seq[5];
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] eg;
      int              c;
`ifdef RDS_FIXED_PRIO_EN
      seq = '{0, 0, 0, 0, 0};
`else
      seq = '{0, 1, 2, 3, 0};
`endif
      data  = {8'h0F, 8'h3C, 8'h55, 8'hC3};
      reset = 1'b0;
      @(negedge clk_2);
      reset = 1'b1;
      m_rr  = 0;
      for (int k = 0; k < 5; k++) sb.push_back(model(seq[k], data[seq[k]]));
      req = '1;
      for (int k = 0; k < 5; k++) begin
         c = 0;
         g = '0;
         while (c < 30 && g == '0) begin
            @(negedge clk_2);
            c++;
            g = grant;
         end
         eg         = '0;
         eg[seq[k]] = 1'b1;
         n_tests++;
         if (g !== eg) begin
            n_fail++; $display("FAIL b2b_grant[%0d]: got %b, required %b", k, g, eg);
         end
         if (k > 0) begin
            n_tests++;
            if (c != NBITS + 3) begin
               n_fail++; $display("FAIL b2b_interval[%0d]: got %0d cycles, required %0d", k, c, NBITS + 3);
            end
         end
      end
      req = '0;
      wait_idle("b2b");
   endtask

   task automatic test_reset_mid_job();
      logic [NREQ-1:0] g;
      int              cyc;
      data[2] = 8'hFF;
      drive_req(4'b0100, g, cyc);
      repeat (3) @(negedge clk_2);
      reset = 1'b0;
      @(negedge clk_2);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || hit_count !== '0) begin
         n_fail++;
         $display("FAIL midjob_abort: got busy=%b done=%b cnt=%0d, required 0/0/0", busy, done, hit_count);
      end
      m_rr    = 0;
      data[0] = 8'h0F;
      sb.push_back(mk(0, 1'b1, 1, 6));
      reset = 1'b1;
      drive_req(4'b0101, g, cyc);
      n_tests++;
      if (g !== 4'b0001) begin
         n_fail++; $display("FAIL midjob_regrant: got %b, required 0001", g);
      end
      wait_idle("midjob");
   endtask

   initial begin
      test_reset();
      test_no_run();
      test_mixed();
      test_all_equal();
      test_random();
      test_back_to_back();
      test_reset_mid_job();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
